adder_share_ctrl: RTL

//  Round-robin scheduler sharing the single DW-bit adder datapath among NUM_REQ requesters.

---
 rtl/adder_share_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/adder_share_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the shared-adder scheduler.
// Build option: define ADD_SAT_EN for unsigned saturating sums.
package adder_share_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam int DW_DEFAULT      = 8;
    localparam int NUM_REQ_DEFAULT = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting at ptr_i and
// returns a one-hot grant plus the index of the winning requester.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int IW = $clog2(NUM_REQ);

    int              pos;
    logic [IW-1:0]   pos_idx;

    // First active request at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            pos_idx = IW'(pos);
            if (!any_o && req_i[pos_idx]) begin
                any_o            = 1'b1;
                grant_o[pos_idx] = 1'b1;
                idx_o            = pos_idx;
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one DW-bit adder among NUM_REQ requesters with round-robin grants.
// One result register feeds a valid/ready response channel; a new grant can
// replace a result in the same cycle it is consumed (one result per cycle).
// Build option: define ADD_SAT_EN to saturate rsp_sum to all-ones on carry.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DW-1:0]      req_a,
    input  logic [NUM_REQ*DW-1:0]      req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DW-1:0]              rsp_sum,
    output logic                       rsp_carry,
    output logic [CNT_W-1:0]           op_count
);

    localparam int IW = $clog2(NUM_REQ);

    // Wrapping sum, or all-ones when the add overflowed in saturating builds.
    function automatic logic [DW-1:0] fmt_sum(input logic [DW:0] raw);
`ifdef ADD_SAT_EN
        return raw[DW] ? {DW{1'b1}} : raw[DW-1:0];
`else
        return raw[DW-1:0];
`endif
    endfunction

    state_e           state_q;
    logic [DW-1:0]    sum_q;
    logic             carry_q;
    logic [IW-1:0]    id_q;
    logic [IW-1:0]    ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               can_accept;
    logic               grant_fire;
    logic               rsp_fire;

    logic [DW-1:0]    a_sel;
    logic [DW-1:0]    b_sel;
    logic [DW:0]      add_d;
    logic [DW-1:0]    sum_d;
    logic [IW-1:0]    ptr_d;
    logic [CNT_W-1:0] cnt_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    // Grant decision: the result slot is free now or is being emptied this
    // cycle; rst_n keeps req_ready low while reset is asserted.
    always_comb begin
        can_accept = rst_n && ena &&
                     ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
        grant_fire = can_accept && gnt_any;
        req_ready  = can_accept ? grant : '0;
        rsp_fire   = (state_q == RESP) && rsp_ready;
        a_sel      = req_a[gnt_idx*DW +: DW];
        b_sel      = req_b[gnt_idx*DW +: DW];
        add_d      = {1'b0, a_sel} + {1'b0, b_sel};
        sum_d      = fmt_sum(add_d);
        ptr_d      = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
    end

    // Response FSM with result, pointer and completion-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (rsp_fire) cnt_q <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        state_q <= RESP;
                        sum_q   <= sum_d;
                        carry_q <= add_d[DW];
                        id_q    <= gnt_idx;
                        ptr_q   <= ptr_d;
                    end
                end
                RESP: begin
                    if (grant_fire) begin
                        sum_q   <= sum_d;
                        carry_q <= add_d[DW];
                        id_q    <= gnt_idx;
                        ptr_q   <= ptr_d;
                    end else if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
    assign op_count  = cnt_q;

endmodule
